// File: rtl/reg_arith_exec.sv
// RV32I register-register arithmetic execute stage with a one-entry output register.
// Optional SERIAL_SHIFT_EN macro: shifts use a 1-bit/cycle shifter instead of a barrel shifter.
//
// Ports:
//   clk, rst                        clock, async active-high reset
//   in_valid/in_ready               upstream handshake
//   in_kind, in_rs1, in_rs2, in_rd  operation, operands, destination index
//   out_valid/out_ready             downstream handshake
//   out_result, out_rd, out_illegal registered result bundle
//   busy                            multi-cycle shift in flight

package opcode_type_pkg;
    typedef enum logic [3:0] {
        rak_add,
        rak_sub,
        rak_slt,
        rak_sltu,
        rak_sll,
        rak_srl,
        rak_sra,
        rak_xor,
        rak_or,
        rak_and,
        rak_invalid
    } reg_arith_kind_t;
endpackage

module reg_arith_exec
    import opcode_type_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  reg_arith_kind_t   in_kind,
    input  logic [XLEN-1:0]   in_rs1,
    input  logic [XLEN-1:0]   in_rs2,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_illegal,
    output logic              busy
);

    localparam int SH_W = $clog2(XLEN);

    logic [SH_W-1:0] w_shamt;
    logic            w_out_free;
    logic            w_accept;
    logic            w_illegal;
    logic            w_slt;
    logic            w_sltu;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_res;

    logic            r_out_valid;
    logic [XLEN-1:0] r_out_result;
    logic [RD_W-1:0] r_out_rd;
    logic            r_out_illegal;

    assign w_shamt    = in_rs2[SH_W-1:0];
    assign w_out_free = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_illegal  = (in_kind == rak_invalid);
    assign w_slt      = $signed(in_rs1) < $signed(in_rs2);
    assign w_sltu     = in_rs1 < in_rs2;

    always_comb begin
        w_alu = '0;
        unique case (in_kind)
            rak_add:  w_alu = in_rs1 + in_rs2;
            rak_sub:  w_alu = in_rs1 - in_rs2;
            rak_slt:  w_alu = {{(XLEN-1){1'b0}}, w_slt};
            rak_sltu: w_alu = {{(XLEN-1){1'b0}}, w_sltu};
            rak_sll:  w_alu = in_rs1 << w_shamt;
            rak_srl:  w_alu = in_rs1 >> w_shamt;
            rak_sra:  w_alu = $signed(in_rs1) >>> w_shamt;
            rak_xor:  w_alu = in_rs1 ^ in_rs2;
            rak_or:   w_alu = in_rs1 | in_rs2;
            rak_and:  w_alu = in_rs1 & in_rs2;
            default:  w_alu = '0;
        endcase
    end

    // x0 is hardwired to zero, but the op still flows through.
    assign w_res = (in_rd == '0) ? '0 : w_alu;

`ifdef SERIAL_SHIFT_EN

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    localparam logic [SH_W-1:0] CNT_ONE = 1;

    state_t          r_state;
    logic [XLEN-1:0] r_acc;
    logic [SH_W-1:0] r_cnt;
    reg_arith_kind_t r_kind;
    logic [RD_W-1:0] r_rd;

    logic            w_is_shift;
    logic            w_serial;

    function automatic logic [XLEN-1:0] f_shift1(
        input reg_arith_kind_t k,
        input logic [XLEN-1:0] v
    );
        logic [XLEN-1:0] r;
        if (k == rak_sll)
            r = {v[XLEN-2:0], 1'b0};
        else if (k == rak_srl)
            r = {1'b0, v[XLEN-1:1]};
        else
            r = {v[XLEN-1], v[XLEN-1:1]};
        return r;
    endfunction

    assign w_is_shift = (in_kind == rak_sll) ||
                        (in_kind == rak_srl) ||
                        (in_kind == rak_sra);
    assign w_serial   = w_is_shift && (w_shamt != '0);

    assign in_ready = !rst && (r_state == S_IDLE) && w_out_free;
    assign busy     = (r_state == S_SHIFT);

    // The first bit is shifted on the accept edge so that a shift by N
    // lands in the output register N+1 cycles after accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_kind        <= rak_add;
            r_rd          <= '0;
            r_out_valid   <= 1'b0;
            r_out_result  <= '0;
            r_out_rd      <= '0;
            r_out_illegal <= 1'b0;
        end else begin
            if (out_ready)
                r_out_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_serial) begin
                            r_state <= S_SHIFT;
                            r_acc   <= f_shift1(in_kind, in_rs1);
                            r_cnt   <= w_shamt - CNT_ONE;
                            r_kind  <= in_kind;
                            r_rd    <= in_rd;
                        end else begin
                            r_out_valid   <= 1'b1;
                            r_out_result  <= w_res;
                            r_out_rd      <= in_rd;
                            r_out_illegal <= w_illegal;
                        end
                    end
                end
                S_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_acc <= f_shift1(r_kind, r_acc);
                        r_cnt <= r_cnt - CNT_ONE;
                    end else if (w_out_free) begin
                        r_state       <= S_IDLE;
                        r_out_valid   <= 1'b1;
                        r_out_result  <= (r_rd == '0) ? '0 : r_acc;
                        r_out_rd      <= r_rd;
                        r_out_illegal <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`else

    assign in_ready = !rst && w_out_free;
    assign busy     = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid   <= 1'b0;
            r_out_result  <= '0;
            r_out_rd      <= '0;
            r_out_illegal <= 1'b0;
        end else if (w_accept) begin
            r_out_valid   <= 1'b1;
            r_out_result  <= w_res;
            r_out_rd      <= in_rd;
            r_out_illegal <= w_illegal;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`endif

    assign out_valid   = r_out_valid;
    assign out_result  = r_out_result;
    assign out_rd      = r_out_rd;
    assign out_illegal = r_out_illegal;

endmodule

// File: tb/tb_reg_arith_exec.sv
// Self-checking bench for reg_arith_exec: directed vectors plus a
// queue-based reference model compared against the outputs every cycle.

module tb_reg_arith_exec;
    import opcode_type_pkg::*;

`ifdef SERIAL_SHIFT_EN
    localparam bit SER = 1'b1;
`else
    localparam bit SER = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    reg_arith_kind_t in_kind;
    logic [31:0]     in_rs1;
    logic [31:0]     in_rs2;
    logic [4:0]      in_rd;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_result;
    logic [4:0]      out_rd;
    logic            out_illegal;
    logic            busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        ill;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   out_cycs[$];

    reg_arith_exec #(.XLEN(32), .RD_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_illegal(out_illegal),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model_res(
        input reg_arith_kind_t k,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [4:0]  rd
    );
        int unsigned sh;
        logic [31:0] r;
        sh = b % 32;
        case (k)
            rak_add:  r = a + b;
            rak_sub:  r = a - b;
            rak_slt:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            rak_sltu: r = (a < b) ? 32'd1 : 32'd0;
            rak_sll:  r = a << sh;
            rak_srl:  r = a >> sh;
            rak_sra:  r = $signed(a) >>> sh;
            rak_xor:  r = a ^ b;
            rak_or:   r = a | b;
            rak_and:  r = a & b;
            default:  r = 32'd0;
        endcase
        if (rd == 5'd0)
            r = 32'd0;
        return r;
    endfunction

    function automatic int model_extra(
        input reg_arith_kind_t k,
        input logic [31:0] b
    );
        int n;
        n = 0;
        if (SER && (k == rak_sll || k == rak_srl || k == rak_sra))
            n = b % 32;
        return n;
    endfunction

    // Reference compare: head of the queue must match whenever out_valid.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL model_spurious cyc=%0d got valid res=%h rd=%0d exp no output",
                             cyc, out_result, out_rd);
                end else begin
                    e = exp_q[0];
                    if (out_result !== e.res || out_rd !== e.rd ||
                        out_illegal !== e.ill || cyc < e.due) begin
                        bad++;
                        $display("FAIL model_cmp cyc=%0d got res=%h rd=%0d ill=%b exp res=%h rd=%0d ill=%b due=%0d",
                                 cyc, out_result, out_rd, out_illegal,
                                 e.res, e.rd, e.ill, e.due);
                    end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        out_cycs.push_back(cyc);
                    end
                end
            end
            if (in_valid && in_ready) begin
                e.res = model_res(in_kind, in_rs1, in_rs2, in_rd);
                e.rd  = in_rd;
                e.ill = (in_kind == rak_invalid);
                e.due = cyc + 1 + model_extra(in_kind, in_rs2);
                exp_q.push_back(e);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic send(
        input reg_arith_kind_t k,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [4:0]  rd
    );
        int n;
        in_valid = 1'b1;
        in_kind  = k;
        in_rs1   = a;
        in_rs2   = b;
        in_rd    = rd;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout got in_ready=0 exp 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(
        input string nm,
        input logic [31:0] res,
        input logic [4:0]  rd,
        input logic        ill,
        input int          exp_lat,
        input int          nb
    );
        int lat;
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (lat <= nb) begin
                chk({nm, "_busy"}, 32'(busy), 32'd1);
                chk({nm, "_inrdy"}, 32'(in_ready), 32'd0);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_res"}, out_result, res);
        chk({nm, "_rd"}, 32'(out_rd), 32'(rd));
        chk({nm, "_ill"}, 32'(out_illegal), 32'(ill));
        chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic op1(
        input string nm,
        input reg_arith_kind_t k,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [4:0]  rd,
        input logic [31:0] res,
        input logic        ill
    );
        int n;
        n = model_extra(k, b);
        send(k, a, b, rd);
        in_valid = 1'b0;
        wait_out(nm, res, rd, ill, n + 1, n);
    endtask

    initial begin
        int acc_c[4];
        int nvalid;
        int n;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_kind   = rak_add;
        in_rs1    = '0;
        in_rs2    = '0;
        in_rd     = '0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_res", out_result, 32'd0);
        chk("rst_rd", 32'(out_rd), 32'd0);
        chk("rst_ill", 32'(out_illegal), 32'd0);
        chk("rst_inrdy", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_inrdy", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Pins on the model itself.
        chk("model_add", model_res(rak_add, 32'd5, 32'd7, 5'd3), 32'd12);
        chk("model_sra", model_res(rak_sra, 32'h8000_0000, 32'h24, 5'd1), 32'hF800_0000);
        chk("model_slt", model_res(rak_slt, 32'hFFFF_FFFF, 32'd1, 5'd1), 32'd1);

        op1("add", rak_add, 32'd5, 32'd7, 5'd3, 32'd12, 1'b0);
        op1("sub", rak_sub, 32'd0, 32'd1, 5'd4, 32'hFFFF_FFFF, 1'b0);
        op1("slt", rak_slt, 32'hFFFF_FFFF, 32'd1, 5'd5, 32'd1, 1'b0);
        op1("sltu", rak_sltu, 32'hFFFF_FFFF, 32'd1, 5'd6, 32'd0, 1'b0);
        op1("add_x0", rak_add, 32'd5, 32'd7, 5'd0, 32'd0, 1'b0);
        op1("xor", rak_xor, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd7, 32'h0FF0_0FF0, 1'b0);
        op1("or", rak_or, 32'h1234_0000, 32'h0000_5678, 5'd8, 32'h1234_5678, 1'b0);
        op1("and", rak_and, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd10, 32'h0F0F_0000, 1'b0);
        op1("sra", rak_sra, 32'h8000_0000, 32'h24, 5'd11, 32'hF800_0000, 1'b0);
        op1("srl", rak_srl, 32'h8000_0000, 32'h24, 5'd12, 32'h0800_0000, 1'b0);
        op1("sll31", rak_sll, 32'd1, 32'h1F, 5'd13, 32'h8000_0000, 1'b0);
        op1("sll_sh0", rak_sll, 32'h0000_ABCD, 32'h20, 5'd14, 32'h0000_ABCD, 1'b0);
        op1("invalid", rak_invalid, 32'd123, 32'd456, 5'd9, 32'd0, 1'b1);

        // Back-to-back adds with no backpressure.
        for (int i = 0; i < 4; i++) begin
            send(rak_add, 32'(i * 3), 32'd100, 5'(i + 1));
            acc_c[i] = cyc;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 1; i < 4; i++)
            chk("b2b_acc_gap", 32'(acc_c[i] - acc_c[i-1]), 32'd1);
        n = out_cycs.size();
        for (int i = 1; i < 4; i++)
            chk("b2b_out_gap", 32'(out_cycs[n-4+i] - out_cycs[n-5+i]), 32'd1);

        // Backpressure: hold out_ready low for three cycles.
        out_ready = 1'b0;
        send(rak_add, 32'd1, 32'd2, 5'd4);
        in_kind  = rak_add;
        in_rs1   = 32'd10;
        in_rs2   = 32'd20;
        in_rd    = 5'd5;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_res", out_result, 32'd3);
            chk("bp_rd", 32'(out_rd), 32'd4);
            chk("bp_inrdy", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_inrdy", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_next_res", out_result, 32'd30);
        chk("bp_next_rd", 32'(out_rd), 32'd5);
        @(posedge clk);
        #1;

        // Reset in the middle of a long shift (or while a result is held).
        out_ready = 1'b0;
        send(rak_sll, 32'd1, 32'd20, 5'd7);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rstmid_busy", 32'(busy), 32'(SER));
        chk("rstmid_pre_valid", 32'(out_valid), 32'(!SER));
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_valid", 32'(out_valid), 32'd0);
        chk("rstmid_busy0", 32'(busy), 32'd0);
        chk("rstmid_inrdy", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid)
                nvalid++;
        end
        chk("rstmid_no_stale", 32'(nvalid), 32'd0);
        @(posedge clk);
        #1;

        op1("after_rst", rak_add, 32'd40, 32'd2, 5'd1, 32'd42, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("drain_q", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
